// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring per transaction,
// full-circle quadrant pre-correction at capture, valid/ready handshake on both sides.
module cordic_iter_engine #(
  parameter int WIDTH    = 32,
  parameter int ITER_MAX = 16,
  parameter int GUARD    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [$clog2(ITER_MAX+1)-1:0] n_iter,
  input  logic [WIDTH-1:0]              x_in,
  input  logic [WIDTH-1:0]              y_in,
  input  logic [WIDTH-1:0]              z_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              x_out,
  output logic [WIDTH-1:0]              y_out,
  output logic [WIDTH-1:0]              z_out
);

  localparam int NW = $clog2(ITER_MAX+1);
  localparam int IW = WIDTH + GUARD;
  localparam int RD = 1 << NW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // atan(2^-i) in binary-angle units; the series converges fast for i >= 1, i = 0 is exactly 1/8 turn.
  function automatic logic [WIDTH-1:0] atan_val(input int i);
    real    t;
    real    p;
    real    s;
    real    scale;
    longint r;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    s = 0.0;
    p = t;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) s = s + p / real'(2 * k + 1);
      else            s = s - p / real'(2 * k + 1);
      p = p * t * t;
    end
    if (i == 0) s = 0.78539816339744830962;
    scale = 1.0;
    for (int k = 0; k < WIDTH; k++) scale = scale * 2.0;
    r = longint'(s * scale / 6.28318530717958647692);
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v[IW-1:WIDTH-1] == {(GUARD+1){v[IW-1]}}) return v[WIDTH-1:0];
    else if (v[IW-1])                             return {1'b1, {(WIDTH-1){1'b0}}};
    else                                          return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic [WIDTH-1:0] atan_rom [RD];

  for (genvar g = 0; g < RD; g++) begin : g_atan
    localparam logic [WIDTH-1:0] ATAN_G = (g < ITER_MAX) ? atan_val(g) : '0;
    assign atan_rom[g] = ATAN_G;
  end

  state_t               state;
  state_t               state_nx;
  logic [NW-1:0]        cnt;
  logic [NW-1:0]        n_r;
  logic                 mode_r;
  logic signed [IW-1:0] x_it;
  logic signed [IW-1:0] y_it;
  logic [WIDTH-1:0]     z_it;

  logic                 accept;
  logic                 last_it;
  logic [NW-1:0]        n_clamp;
  logic                 flip;
  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] x_pre;
  logic signed [IW-1:0] y_pre;
  logic [WIDTH-1:0]     z_pre;

  logic                 d_pos;
  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;
  logic signed [IW-1:0] x_nx;
  logic signed [IW-1:0] y_nx;
  logic [WIDTH-1:0]     z_nx;
  logic [WIDTH-1:0]     atan_c;

  assign accept  = in_valid && in_ready;
  assign last_it = (cnt == n_r - NW'(1));

  // Capture: clamp the iteration count and fold the operand into +-90 degrees.
  always_comb begin
    n_clamp = (n_iter > NW'(ITER_MAX)) ? NW'(ITER_MAX) : n_iter;
    x_ext   = {{GUARD{x_in[WIDTH-1]}}, x_in};
    y_ext   = {{GUARD{y_in[WIDTH-1]}}, y_in};
    flip    = mode ? x_in[WIDTH-1] : (z_in[WIDTH-1] ^ z_in[WIDTH-2]);
    x_pre   = flip ? -x_ext : x_ext;
    y_pre   = flip ? -y_ext : y_ext;
    // Adding or subtracting half a turn is the same modulo 2^WIDTH: flip the MSB.
    z_pre   = flip ? {~z_in[WIDTH-1], z_in[WIDTH-2:0]} : z_in;
  end

  // Micro-rotation for the current iteration index.
  always_comb begin
    d_pos  = mode_r ? y_it[IW-1] : ~z_it[WIDTH-1];
    x_sh   = x_it >>> cnt;
    y_sh   = y_it >>> cnt;
    atan_c = atan_rom[cnt];
    if (d_pos) begin
      x_nx = x_it - y_sh;
      y_nx = y_it + x_sh;
      z_nx = z_it - atan_c;
    end else begin
      x_nx = x_it + y_sh;
      y_nx = y_it - x_sh;
      z_nx = z_it + atan_c;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (n_clamp == '0) ? DONE : RUN;
      end
      RUN:     if (last_it) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      n_r       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= '0;
        n_r <= n_clamp;
      end else if (state == RUN) begin
        cnt <= cnt + NW'(1);
      end
      // Results land in the output registers on entry to DONE; valid follows one cycle later.
      if (state == DONE && !out_valid)     out_valid <= 1'b1;
      else if (out_valid && out_ready)     out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (accept && n_clamp == '0) begin
      x_out <= sat(x_pre);
      y_out <= sat(y_pre);
      z_out <= z_pre;
    end else if (state == RUN && last_it) begin
      x_out <= sat(x_nx);
      y_out <= sat(y_nx);
      z_out <= z_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mode_r <= mode;
      x_it   <= x_pre;
      y_it   <= y_pre;
      z_it   <= z_pre;
    end else if (state == RUN) begin
      x_it <= x_nx;
      y_it <= y_nx;
      z_it <= z_nx;
    end
  end

endmodule
